// File: rtl/mem_access.sv
// mem_access: data-memory access stage.
// Takes the effective address and store data from execute, then runs one
// load or store over a req/ack bus. Returns an extended load value, a
// misaligned flag or a bus-timeout flag to writeback.
// Ports:
//   clk, rst (async active-low)
//   start, is_load, is_store, funct3, addr, store_data : request from execute
//   busy, done, load_data, misaligned, bus_err         : status/result
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb     : bus request
//   mem_ack, mem_rdata                                  : bus response
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    k_q, k_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   ld_q, ld_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Request decode (evaluated on the incoming request in IDLE)
  logic        st_in, ld_in, legal, aligned, fault;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  always_comb begin
    st_in = is_store;
    ld_in = is_load & ~is_store;   // store wins when both are set

    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~st_in;  // unsigned forms are load-only
      default:                legal = 1'b0;
    endcase

    case (funct3)
      3'b001, 3'b101: aligned = ~addr[0];
      3'b010:         aligned = (addr[1:0] == 2'b00);
      default:        aligned = 1'b1;
    endcase

    fault = (st_in | ld_in) & ~(legal & aligned);

    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend
  logic [31:0] rsh, ld_ext;

  always_comb begin
    rsh = mem_rdata >> {k_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ld_ext = {24'h0, rsh[7:0]};
      3'b101:  ld_ext = {16'h0, rsh[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    k_d     = k_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          ld_d    = '0;
          mis_d   = 1'b0;
          berr_d  = 1'b0;
          cnt_d   = '0;
          we_d    = st_in;
          f3_d    = funct3;
          k_d     = addr[1:0];
          waddr_d = addr[31:2];
          wdata_d = st_in ? lane_wdata : '0;
          wstrb_d = st_in ? lane_wstrb : '0;
          if (!(st_in | ld_in)) begin
            state_d = DONE;
          end else if (fault) begin
            mis_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          if (!we_q) ld_d = ld_ext;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      k_q     <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      k_q     <= k_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs are gated by the REQ state so they read 0 outside an access
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign mem_req    = (state_q == REQ);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? {waddr_q, 2'b00} : '0;
  assign mem_wdata  = mem_req ? wdata_q : '0;
  assign mem_wstrb  = mem_req ? wstrb_q : '0;
  assign misaligned = done & mis_q;
  assign bus_err    = done & berr_q;
  assign load_data  = ld_q;

endmodule
